// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer: multi-cycle shifter built on a one-position ALU shift.
// Shared ALU types plus the sequencer that iterates the ALU for 0-31 steps.
package alu_shift_pkg;
    typedef logic [31:0] t_reg;

    typedef enum logic [2:0] {
        OP_TEST        = 3'd0,
        OP_LOGIC_LEFT  = 3'd1,
        OP_LOGIC_RIGHT = 3'd2,
        OP_ARITH_LEFT  = 3'd3,
        OP_ARITH_RIGHT = 3'd4
    } t_alu_op;
endpackage

module alu_shift_sequencer
    import alu_shift_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] kind,
    input  t_reg       value,
    input  logic [4:0] count,
    output logic       busy,
    output logic       done,
    output t_reg       result,
    output logic       carry_out,
    output logic       zero_out,
    output logic       neg_out,
    output logic       over_out,
    output t_alu_op    alu_op,
    output t_reg       alu_reg2,
    output t_reg       alu_reg3,
    output logic       alu_carry_in,
    input  t_reg       alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       alu_over
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    t_reg       acc;
    logic [4:0] remaining;
    t_alu_op    op_q;
    logic       over_sticky;
    logic       accept;
    logic       last_step;
    logic       op_is_test;
    logic       op_is_arith_left;
    logic       over_next;
    t_alu_op    kind_op;

    assign accept           = start && (state != S_RUN);
    assign last_step        = (remaining <= 5'd1);
    assign op_is_test       = (op_q == OP_TEST);
    assign op_is_arith_left = (op_q == OP_ARITH_LEFT);
    assign over_next        = over_sticky | alu_over;

    assign alu_reg2     = acc;
    assign alu_reg3     = '0;
    assign alu_carry_in = 1'b0;

    // Translate the request kind into the ALU single-step opcode.
    always_comb begin
        kind_op = OP_TEST;
        unique case (kind)
            2'd0:    kind_op = OP_LOGIC_LEFT;
            2'd1:    kind_op = OP_LOGIC_RIGHT;
            2'd2:    kind_op = OP_ARITH_LEFT;
            default: kind_op = OP_ARITH_RIGHT;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next state plus handshake and ALU op drive.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        alu_op   = OP_TEST;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_nx = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                alu_op = op_q;
                if (last_step)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = start ? S_RUN : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Accumulator iteration and final result/flag capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            remaining   <= '0;
            op_q        <= OP_TEST;
            over_sticky <= 1'b0;
            result      <= '0;
            carry_out   <= 1'b0;
            zero_out    <= 1'b0;
            neg_out     <= 1'b0;
            over_out    <= 1'b0;
        end else if (accept) begin
            acc         <= value;
            remaining   <= count;
            op_q        <= (count == 5'd0) ? OP_TEST : kind_op;
            over_sticky <= 1'b0;
        end else if (state == S_RUN) begin
            acc         <= alu_result;
            over_sticky <= over_next;
            if (remaining != 5'd0)
                remaining <= remaining - 5'd1;
            if (last_step) begin
                result    <= alu_result;
                carry_out <= alu_carry & ~op_is_test;
                zero_out  <= alu_zero;
                neg_out   <= alu_neg;
                over_out  <= over_next & op_is_arith_left;
            end
        end
    end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Bench for alu_shift_sequencer with a behavioural one-step ALU.
// Scoreboard queue filled by stimulus, drained by a done-driven monitor.
module tb_alu_shift_sequencer;
    import alu_shift_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] kind = '0;
    t_reg       value = '0;
    logic [4:0] count = '0;
    logic       busy;
    logic       done;
    t_reg       result;
    logic       carry_out;
    logic       zero_out;
    logic       neg_out;
    logic       over_out;
    t_alu_op    alu_op;
    t_reg       alu_reg2;
    t_reg       alu_reg3;
    logic       alu_carry_in;
    t_reg       alu_result;
    logic       alu_carry;
    logic       alu_zero;
    logic       alu_neg;
    logic       alu_over;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_shift_sequencer dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .kind(kind),
        .value(value),
        .count(count),
        .busy(busy),
        .done(done),
        .result(result),
        .carry_out(carry_out),
        .zero_out(zero_out),
        .neg_out(neg_out),
        .over_out(over_out),
        .alu_op(alu_op),
        .alu_reg2(alu_reg2),
        .alu_reg3(alu_reg3),
        .alu_carry_in(alu_carry_in),
        .alu_result(alu_result),
        .alu_carry(alu_carry),
        .alu_zero(alu_zero),
        .alu_neg(alu_neg),
        .alu_over(alu_over)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Single-position ALU reference.
    always_comb begin
        alu_result = alu_reg2 | alu_reg3;
        alu_carry  = 1'b0;
        alu_over   = 1'b0;
        case (alu_op)
            OP_LOGIC_LEFT: begin
                alu_result = {alu_reg2[30:0], 1'b0};
                alu_carry  = alu_reg2[31];
            end
            OP_LOGIC_RIGHT: begin
                alu_result = {1'b0, alu_reg2[31:1]};
                alu_carry  = alu_reg2[0];
            end
            OP_ARITH_LEFT: begin
                alu_result = {alu_reg2[30:0], 1'b0};
                alu_carry  = alu_reg2[31];
                alu_over   = alu_reg2[31] ^ alu_reg2[30];
            end
            OP_ARITH_RIGHT: begin
                alu_result = {alu_reg2[31], alu_reg2[31:1]};
                alu_carry  = alu_reg2[0];
            end
            default: ;
        endcase
        alu_zero = (alu_result == '0);
        alu_neg  = alu_result[31];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("result", result, e.res);
                chk("carry", {31'd0, carry_out}, {31'd0, e.c});
                chk("zero", {31'd0, zero_out}, {31'd0, e.z});
                chk("neg", {31'd0, neg_out}, {31'd0, e.n});
                chk("over", {31'd0, over_out}, {31'd0, e.v});
                chk("busy_in_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] k, input logic [31:0] v,
                         input logic [4:0] n, input logic [31:0] er,
                         input logic ec, input logic ez, input logic en,
                         input logic ev, input bit push);
        exp_t e;
        kind  = k;
        value = v;
        count = n;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        e.res = er;
        e.c   = ec;
        e.z   = ez;
        e.n   = en;
        e.v   = ev;
        e.cyc = cyc + ((n == 5'd0) ? 1 : int'(n));
        if (push)
            sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (done === 1'b1)
                seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, carry_out, zero_out, neg_out, over_out}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        issue(2'd0, 32'h8080_8080, 5'd1, 32'h0101_0100, 1, 0, 0, 0, 1);
        wait_done("t1");
        issue(2'd1, 32'hffff_ffff, 5'd4, 32'h0fff_ffff, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t2_busy", {31'd0, busy}, 32'd1);
        end
        wait_done("t2");
        issue(2'd3, 32'h8000_0000, 5'd31, 32'hffff_ffff, 0, 0, 1, 0, 1);
        wait_done("t3");
        issue(2'd2, 32'h4000_0001, 5'd2, 32'h0000_0004, 1, 0, 0, 1, 1);
        wait_done("t4");
        issue(2'd2, 32'h0000_0003, 5'd3, 32'h0000_0018, 0, 0, 0, 0, 1);
        wait_done("t4b");
        issue(2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 0, 0, 1, 0, 1);
        wait_done("t4c");

        issue(2'd0, 32'h0000_0000, 5'd0, 32'h0000_0000, 0, 1, 0, 0, 1);
        wait_done("t5a");
        issue(2'd1, 32'h0000_0001, 5'd1, 32'h0000_0000, 1, 1, 0, 0, 1);
        wait_done("t5b");
        @(negedge clock);
        chk("t5_held", result, 32'h0000_0000);

        issue(2'd0, 32'h0000_00ff, 5'd8, 32'h0000_ff00, 0, 0, 0, 0, 1);
        @(posedge clock);
        #1;
        kind  = 2'd1;
        value = 32'hdead_beef;
        count = 5'd3;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done("t6");
        @(negedge clock);
        chk("t6_hold", result, 32'h0000_ff00);

        issue(2'd3, 32'h8000_0000, 5'd8, 32'h0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("rr_busy", {31'd0, busy}, 32'd0);
        chk("rr_done", {31'd0, done}, 32'd0);
        chk("rr_result", result, 32'd0);
        chk("rr_flags", {28'd0, carry_out, zero_out, neg_out, over_out}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        issue(2'd3, 32'h8000_0010, 5'd4, 32'hf800_0001, 0, 0, 1, 0, 1);
        wait_done("t7");
        repeat (3) @(negedge clock);
        chk("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
